// File: rtl/serial_addsub.sv
// Purpose : bit-serial unsigned adder/subtractor, one full-adder/subtractor cell reused LSB first.
// Latency : done pulses on the edge after the WIDTH-th RUN cycle (WIDTH+1 edges counting the start edge).
// Backpressure: none; start is only accepted in IDLE, and is ignored while busy (RUN/DONE).
//
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   start, sub, a, b  - operation request; sub=0 -> a+b, sub=1 -> a-b; all sampled with start in IDLE
//   busy              - high in RUN and DONE
//   done              - one-cycle completion pulse (the cycle spent in DONE)
//   result, cbo       - sum/difference mod 2^WIDTH and carry-out/borrow-out, held until next completion
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cbo
);

    // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             op_sub;
    logic             cb;
    logic [CW-1:0]    cnt;

    logic             bit_a;
    logic             bit_b;
    logic             bit_s;
    logic             cb_nxt;
    logic [WIDTH:0]   acc_ext;
    logic             last_bit;

    // Single bit cell: sum and difference bits are identical, only the carry/borrow differs.
    always_comb begin
        bit_a = a_sh[0];
        bit_b = b_sh[0];
        bit_s = bit_a ^ bit_b ^ cb;
        if (op_sub) begin
            cb_nxt = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & cb);
        end else begin
            cb_nxt = (bit_a & bit_b) | (cb & (bit_a ^ bit_b));
        end
        // New bit enters at the MSB; the extended vector avoids a [WIDTH-1:1] slice that is empty at WIDTH=1.
        acc_ext  = {bit_s, acc};
        last_bit = (cnt == LAST);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand shifters, accumulator, carry/borrow flop, bit counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            op_sub <= 1'b0;
            cb     <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cbo    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        op_sub <= sub;
                        acc    <= '0;
                        cb     <= 1'b0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    acc  <= acc_ext[WIDTH:1];
                    cb   <= cb_nxt;
                    cnt  <= cnt + 1'b1;
                    // The last bit is folded in on the same edge that enters DONE.
                    if (last_bit) begin
                        result <= acc_ext[WIDTH:1];
                        cbo    <= cb_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: an 8-bit and a 1-bit instance share clock and reset.
// Expected values come from plain integer arithmetic on the operands.
module tb_serial_addsub;

    logic       clk;
    logic       rst_n;

    logic       st8, sb8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cbo8;
    logic [7:0] res8;

    logic       st1, sb1;
    logic [0:0] a1, b1;
    logic       busy1, done1, cbo1;
    logic [0:0] res1;

    int n_chk;
    int n_fail;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (st8),
        .sub    (sb8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .result (res8),
        .cbo    (cbo8)
    );

    serial_addsub #(.WIDTH(1)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (st1),
        .sub    (sb1),
        .a      (a1),
        .b      (b1),
        .busy   (busy1),
        .done   (done1),
        .result (res1),
        .cbo    (cbo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: unsigned arithmetic, carry = bit WIDTH of the sum, borrow = (x < y).
    task automatic model8(input logic s, input logic [7:0] x, input logic [7:0] y,
                          output logic [7:0] er, output logic ec);
        int unsigned sum;
        if (s) begin
            sum = (32'(x) + 32'd256 - 32'(y)) % 32'd256;
            er  = 8'(sum);
            ec  = (x < y);
        end else begin
            sum = 32'(x) + 32'(y);
            er  = 8'(sum % 32'd256);
            ec  = (sum >= 32'd256);
        end
    endtask

    // One full 8-bit operation; operands are scrambled right after the start edge.
    // Edge count includes the edge that samples start, so done is expected on edge 9.
    task automatic op8(input logic s, input logic [7:0] x, input logic [7:0] y, input string tag);
        logic [7:0] er;
        logic       ec;
        int         n;
        model8(s, x, y, er, ec);
        @(negedge clk);
        st8 = 1'b1; sb8 = s; a8 = x; b8 = y;
        @(negedge clk);
        st8 = 1'b0; sb8 = ~s; a8 = 8'($urandom); b8 = 8'($urandom);
        chk({tag, " busy_run"}, 32'(busy8), 32'd1);
        n = 1;
        while (done8 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, n, 32'd9);
        chk({tag, " result"}, 32'(res8), 32'(er));
        chk({tag, " cbo"}, 32'(cbo8), 32'(ec));
        @(negedge clk);
        chk({tag, " done_low"}, 32'(done8), 32'd0);
        chk({tag, " idle"}, 32'(busy8), 32'd0);
    endtask

    // One 1-bit operation: done is expected on edge 2 counting the start edge.
    task automatic op1(input logic s, input logic x, input logic y, input string tag);
        int er;
        int ec;
        int n;
        if (s) begin
            er = (int'(x) - int'(y) + 2) % 2;
            ec = (int'(x) < int'(y)) ? 1 : 0;
        end else begin
            er = (int'(x) + int'(y)) % 2;
            ec = (int'(x) + int'(y)) / 2;
        end
        @(negedge clk);
        st1 = 1'b1; sb1 = s; a1 = x; b1 = y;
        @(negedge clk);
        st1 = 1'b0; sb1 = ~s; a1 = ~x; b1 = ~y;
        n = 1;
        while (done1 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, n, 32'd2);
        chk({tag, " result"}, 32'(res1), 32'(er));
        chk({tag, " cbo"}, 32'(cbo1), 32'(ec));
    endtask

    initial begin
        int n;
        int dones;
        logic       rs;
        logic [7:0] ra, rb;

        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        st8 = 1'b0; sb8 = 1'b0; a8 = '0; b8 = '0;
        st1 = 1'b0; sb1 = 1'b0; a1 = '0; b1 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst busy8", 32'(busy8), 32'd0);
        chk("rst done8", 32'(done8), 32'd0);
        chk("rst res8", 32'(res8), 32'd0);
        chk("rst cbo8", 32'(cbo8), 32'd0);
        chk("rst busy1", 32'(busy1), 32'd0);
        chk("rst res1", 32'(res1), 32'd0);
        rst_n = 1'b1;

        // Directed corner cases
        op8(1'b0, 8'd200, 8'd100, "add200_100");
        chk("add200_100 exact res", 32'(res8), 32'd44);
        chk("add200_100 exact cbo", 32'(cbo8), 32'd1);
        op8(1'b1, 8'd5, 8'd3, "sub5_3");
        chk("sub5_3 exact res", 32'(res8), 32'd2);
        chk("sub5_3 exact cbo", 32'(cbo8), 32'd0);
        op8(1'b1, 8'd3, 8'd5, "sub3_5");
        chk("sub3_5 exact res", 32'(res8), 32'd254);
        chk("sub3_5 exact cbo", 32'(cbo8), 32'd1);
        op8(1'b1, 8'd0, 8'd0, "sub0_0");
        chk("sub0_0 exact res", 32'(res8), 32'd0);
        chk("sub0_0 exact cbo", 32'(cbo8), 32'd0);
        op8(1'b0, 8'd255, 8'd1, "add255_1");
        chk("add255_1 exact res", 32'(res8), 32'd0);
        chk("add255_1 exact cbo", 32'(cbo8), 32'd1);

        // Random operations
        for (int i = 0; i < 20; i++) begin
            rs = 1'($urandom);
            ra = 8'($urandom);
            rb = 8'($urandom);
            op8(rs, ra, rb, "rand");
        end

        // Result holds while idle with inputs wiggling
        op8(1'b0, 8'd200, 8'd100, "hold_setup");
        repeat (5) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); sb8 = 1'($urandom);
        end
        chk("hold res", 32'(res8), 32'd44);
        chk("hold cbo", 32'(cbo8), 32'd1);

        // start during RUN and during the done cycle must be ignored
        @(negedge clk);
        st8 = 1'b1; sb8 = 1'b1; a8 = 8'd3; b8 = 8'd5;
        @(negedge clk);
        st8 = 1'b0;
        n = 1;
        repeat (2) begin
            @(negedge clk);
            n++;
        end
        st8 = 1'b1; sb8 = 1'b0; a8 = 8'd1; b8 = 8'd1;
        @(negedge clk);
        n++;
        st8 = 1'b0;
        chk("ign_run busy", 32'(busy8), 32'd1);
        while (done8 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ign_run latency", n, 32'd9);
        chk("ign_run res", 32'(res8), 32'd254);
        chk("ign_run cbo", 32'(cbo8), 32'd1);
        st8 = 1'b1; sb8 = 1'b0; a8 = 8'd9; b8 = 8'd9;
        @(negedge clk);
        st8 = 1'b0;
        chk("ign_done busy", 32'(busy8), 32'd0);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 === 1'b1) dones++;
        end
        chk("ign_done extra_dones", dones, 32'd0);
        chk("ign_done res", 32'(res8), 32'd254);

        // Reset mid-operation (cycle 4 of RUN), held low for 3 ns
        @(negedge clk);
        st8 = 1'b1; sb8 = 1'b0; a8 = 8'd100; b8 = 8'd50;
        @(negedge clk);
        st8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort pre busy", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy8), 32'd0);
        chk("abort res", 32'(res8), 32'd0);
        chk("abort cbo", 32'(cbo8), 32'd0);
        chk("abort done", 32'(done8), 32'd0);
        #2;
        rst_n = 1'b1;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8 === 1'b1) dones++;
        end
        chk("abort no_done", dones, 32'd0);
        chk("abort res_after", 32'(res8), 32'd0);
        op8(1'b0, 8'd7, 8'd9, "post_rst");
        chk("post_rst exact res", 32'(res8), 32'd16);
        chk("post_rst exact cbo", 32'(cbo8), 32'd0);

        // WIDTH=1 truth table, all {sub, a, b}
        for (int k = 0; k < 8; k++) begin
            op1(k[2], k[1], k[0], $sformatf("w1_%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
